// File: rtl/mem_responder.sv
// Shared single-port 64-bit SRAM responder terminating the core's ibus and dbus,
// with round-robin arbitration, fixed access latency and range checking.
package mem_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       access_fault
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] SPAN_BYTES = 64'(DEPTH_WORDS) << 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Everything remembered about the granted request until it retires.
    typedef struct packed {
        logic             is_dbus;
        logic             in_range;
        logic [IDX_W-1:0] idx;
        logic             half;
        logic [2:0]       size;
        logic [7:0]       strobe;
        logic [63:0]      data;
    } txn_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_dbus_q, rr_dbus_d;
    txn_t             txn_q, txn_d;

    ibus_resp_t       iresp_d;
    dbus_resp_t       dresp_d;
    logic             fault_d;

    logic             grant_dbus;
    logic [63:0]      req_addr;
    logic [63:0]      req_off;
    logic [63:0]      rd_word;

    logic [63:0]      mem [DEPTH_WORDS];

    // Requester selection: the favoured side wins a tie, otherwise whoever is valid.
    always_comb begin
        grant_dbus = dreq.valid && (!ireq.valid || rr_dbus_q);
        req_addr   = grant_dbus ? dreq.addr : ireq.addr;
        req_off    = req_addr - BASE_ADDR;
    end

    // Next-state, latency counter, arbitration pointer and request latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_dbus_d = rr_dbus_q;
        txn_d     = txn_q;

        unique case (state_q)
            IDLE: begin
                if (ireq.valid || dreq.valid) begin
                    if (ireq.valid && dreq.valid) begin
                        rr_dbus_d = !rr_dbus_q;
                    end
                    txn_d.is_dbus  = grant_dbus;
                    txn_d.in_range = (req_addr >= BASE_ADDR) && (req_off < SPAN_BYTES);
                    txn_d.idx      = req_off[3 +: IDX_W];
                    txn_d.half     = req_addr[2];
                    txn_d.size     = grant_dbus ? dreq.size : 3'd0;
                    txn_d.strobe   = grant_dbus ? dreq.strobe : 8'd0;
                    txn_d.data     = grant_dbus ? dreq.data : 64'd0;
                    cnt_d          = CNT_W'(LATENCY - 1);
                    state_d        = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response payload, sampled from the SRAM on the edge that enters RESP.
    always_comb begin
        rd_word = mem[txn_d.idx];
        iresp_d = '0;
        dresp_d = '0;
        fault_d = 1'b0;
        if (state_d == RESP) begin
            fault_d = !txn_d.in_range;
            if (txn_d.is_dbus) begin
                dresp_d.addr_ok = 1'b1;
                dresp_d.data_ok = 1'b1;
                dresp_d.data    = (txn_d.in_range && (txn_d.strobe == 8'd0)) ? rd_word : 64'd0;
            end else begin
                iresp_d.addr_ok = 1'b1;
                iresp_d.data_ok = 1'b1;
                if (txn_d.in_range) begin
                    iresp_d.data = txn_d.half ? rd_word[63:32] : rd_word[31:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_dbus_q    <= 1'b1;
            txn_q        <= '0;
            iresp        <= '0;
            dresp        <= '0;
            access_fault <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_dbus_q    <= rr_dbus_d;
            txn_q        <= txn_d;
            iresp        <= iresp_d;
            dresp        <= dresp_d;
            access_fault <= fault_d;
        end
    end

    // Byte-masked write commits on the edge that leaves RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if ((state_q == RESP) && txn_q.is_dbus && txn_q.in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (txn_q.strobe[b]) begin
                    mem[txn_q.idx][8*b +: 8] <= txn_q.data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a randomized
// read/write mix checked against a word-array memory model.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int unsigned DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          LAT   = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;

    ibus_req_t  ireq  = '0;
    ibus_resp_t iresp;
    dbus_req_t  dreq  = '0;
    dbus_resp_t dresp;
    logic       access_fault;

    ibus_req_t  i1req = '0;
    ibus_resp_t i1resp;
    dbus_req_t  d1req = '0;
    dbus_resp_t d1resp;
    logic       access_fault1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
        .dreq(dreq), .dresp(dresp), .access_fault(access_fault)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .ireq(i1req), .iresp(i1resp),
        .dreq(d1req), .dresp(d1resp), .access_fault(access_fault1)
    );

    // One dbus transaction on the LATENCY=2 instance, started from an idle responder.
    task automatic dbus_txn(input logic [63:0] addr, input logic [7:0] strobe, input logic [63:0] wdata,
                            input bit drop, output logic [63:0] rdata, output logic fault,
                            output int lat, output bit stray);
        @(posedge clk); @(negedge clk);
        dreq.valid = 1'b1; dreq.addr = addr; dreq.size = 3'd3; dreq.strobe = strobe; dreq.data = wdata;
        lat = -1; stray = 1'b0; rdata = '0; fault = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (drop && c == 1) dreq.valid = 1'b0;
            if (iresp.addr_ok || iresp.data_ok || (dresp.addr_ok != dresp.data_ok) ||
                (access_fault && !dresp.data_ok)) stray = 1'b1;
            if (dresp.data_ok) begin lat = c; rdata = dresp.data; fault = access_fault; end
        end
        dreq = '0;
    endtask

    task automatic ibus_txn(input logic [63:0] addr, output logic [31:0] rdata, output logic fault,
                            output int lat, output bit stray);
        @(posedge clk); @(negedge clk);
        ireq.valid = 1'b1; ireq.addr = addr;
        lat = -1; stray = 1'b0; rdata = '0; fault = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (dresp.addr_ok || dresp.data_ok || (iresp.addr_ok != iresp.data_ok) ||
                (access_fault && !iresp.data_ok)) stray = 1'b1;
            if (iresp.data_ok) begin lat = c; rdata = iresp.data; fault = access_fault; end
        end
        ireq = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (iresp !== '0) begin n_fail++; $display("FAIL reset_iresp: got %h expected 0", iresp); end
        n_checks++; if (dresp !== '0) begin n_fail++; $display("FAIL reset_dresp: got %h expected 0", dresp); end
        n_checks++; if (access_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", access_fault); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({iresp, dresp, access_fault, i1resp, d1resp, access_fault1} !== '0) begin
            n_fail++; $display("FAIL reset_release_idle: got iresp=%h dresp=%h expected all 0", iresp, dresp);
        end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; logic f; int lat; bit st;
        dbus_txn(BASE + 64'h10, 8'hFF, 64'h1122334455667788, 1'b0, rd, f, lat, st);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (rd !== 64'd0 || f !== 1'b0 || st) begin
            n_fail++; $display("FAIL wr_resp: got data=%h fault=%b stray=%b expected 0/0/0", rd, f, st); end
        dbus_txn(BASE + 64'h10, 8'h00, 64'd0, 1'b0, rd, f, lat, st);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (rd !== 64'h1122334455667788 || f !== 1'b0 || st) begin
            n_fail++; $display("FAIL rd_data: got %h fault=%b stray=%b expected 1122334455667788", rd, f, st); end
    endtask

    task automatic test_partial_write();
        logic [63:0] rd; logic [31:0] rd32; logic f; int lat; bit st;
        dbus_txn(BASE + 64'h10, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, rd, f, lat, st);
        ibus_txn(BASE + 64'h10, rd32, f, lat, st);
        n_checks++; if (rd32 !== 32'hAAAAAAAA || lat !== LAT || st) begin
            n_fail++; $display("FAIL ibus_lo: got %h lat=%0d stray=%b expected aaaaaaaa", rd32, lat, st); end
        ibus_txn(BASE + 64'h14, rd32, f, lat, st);
        n_checks++; if (rd32 !== 32'h11223344 || lat !== LAT || st) begin
            n_fail++; $display("FAIL ibus_hi: got %h lat=%0d stray=%b expected 11223344", rd32, lat, st); end
        dbus_txn(BASE + 64'h10, 8'h00, 64'd0, 1'b0, rd, f, lat, st);
        n_checks++; if (rd !== 64'h11223344AAAAAAAA) begin
            n_fail++; $display("FAIL partial_word: got %h expected 11223344aaaaaaaa", rd); end
    endtask

    task automatic test_arbitration();
        int port [4] = '{default: -1};
        int n_resp; int first; bit prev_ok; bit both; bit consec;
        logic [31:0] exp_i; logic [31:0] rd32; logic f; int lat; bit st;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ireq.valid = 1'b1; ireq.addr = BASE + 64'h10;
        dreq.valid = 1'b1; dreq.addr = BASE + 64'h10; dreq.size = 3'd3; dreq.strobe = 8'h00;
        n_resp = 0; prev_ok = 1'b0; both = 1'b0; consec = 1'b0;
        for (int c = 0; c < 40 && n_resp < 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (iresp.data_ok && dresp.data_ok) both = 1'b1;
            if ((iresp.data_ok || dresp.data_ok) && prev_ok) consec = 1'b1;
            prev_ok = iresp.data_ok || dresp.data_ok;
            if (dresp.data_ok) begin
                port[n_resp] = 1;
                n_checks++; if (dresp.data !== 64'h11223344AAAAAAAA) begin
                    n_fail++; $display("FAIL arb_dbus_data: got %h expected 11223344aaaaaaaa", dresp.data); end
                n_resp++;
            end else if (iresp.data_ok) begin
                port[n_resp] = 0;
                exp_i = ireq.addr[2] ? 32'h11223344 : 32'hAAAAAAAA;
                n_checks++; if (iresp.data !== exp_i) begin
                    n_fail++; $display("FAIL arb_ibus_data: got %h expected %h", iresp.data, exp_i); end
                ireq.addr = ireq.addr ^ 64'h4;
                n_resp++;
            end
        end
        ireq = '0; dreq = '0;
        n_checks++; if (n_resp !== 4) begin n_fail++; $display("FAIL arb_count: got %0d expected 4", n_resp); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (port[k] !== ((k % 2 == 0) ? 1 : 0)) begin
                n_fail++; $display("FAIL arb_order[%0d]: got %0d expected %0d (1=dbus)", k, port[k], (k % 2 == 0) ? 1 : 0); end
        end
        n_checks++; if (both || consec) begin
            n_fail++; $display("FAIL arb_pulse: got both=%b consecutive=%b expected 0/0", both, consec); end

        // A lone ibus request must not move the pointer away from dbus.
        ibus_txn(BASE + 64'h10, rd32, f, lat, st);
        n_checks++; if (rd32 !== 32'hAAAAAAAA || lat !== LAT || st) begin
            n_fail++; $display("FAIL arb_single: got %h lat=%0d expected aaaaaaaa lat=%0d", rd32, lat, LAT); end
        ireq.valid = 1'b1; ireq.addr = BASE + 64'h10;
        dreq.valid = 1'b1; dreq.addr = BASE + 64'h10; dreq.size = 3'd3;
        first = -1;
        for (int c = 0; c < 20 && first < 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (dresp.data_ok) first = 1;
            else if (iresp.data_ok) first = 0;
        end
        ireq = '0; dreq = '0;
        n_checks++; if (first !== 1) begin n_fail++; $display("FAIL arb_pointer_kept: got %0d expected 1 (dbus)", first); end
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd; logic [31:0] rd32; logic f; int lat; bit st;
        logic [63:0] w_first; logic [63:0] w_last; logic [63:0] a_last;
        w_first = 64'h0123456789ABCDEF;
        w_last  = 64'hFEDCBA9876543210;
        a_last  = BASE + 64'(8 * (DEPTH - 1));
        dbus_txn(BASE, 8'hFF, w_first, 1'b0, rd, f, lat, st);
        dbus_txn(a_last, 8'hFF, w_last, 1'b0, rd, f, lat, st);
        dbus_txn(64'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, rd, f, lat, st);
        n_checks++; if (f !== 1'b1 || lat !== LAT || rd !== 64'd0 || st) begin
            n_fail++; $display("FAIL oor_write: got fault=%b lat=%0d data=%h stray=%b expected 1/%0d/0/0", f, lat, rd, st, LAT); end
        dbus_txn(BASE + 64'(8 * DEPTH), 8'h00, 64'd0, 1'b0, rd, f, lat, st);
        n_checks++; if (f !== 1'b1 || lat !== LAT || rd !== 64'd0 || st) begin
            n_fail++; $display("FAIL oor_read: got fault=%b lat=%0d data=%h stray=%b expected 1/%0d/0/0", f, lat, rd, st, LAT); end
        ibus_txn(BASE - 64'd4, rd32, f, lat, st);
        n_checks++; if (f !== 1'b1 || lat !== LAT || rd32 !== 32'd0 || st) begin
            n_fail++; $display("FAIL oor_ibus: got fault=%b lat=%0d data=%h expected 1/%0d/0", f, lat, rd32, LAT); end
        dbus_txn(a_last, 8'h00, 64'd0, 1'b0, rd, f, lat, st);
        n_checks++; if (rd !== w_last || f !== 1'b0) begin
            n_fail++; $display("FAIL oor_last_kept: got %h fault=%b expected %h", rd, f, w_last); end
        dbus_txn(BASE, 8'h00, 64'd0, 1'b0, rd, f, lat, st);
        n_checks++; if (rd !== w_first || f !== 1'b0) begin
            n_fail++; $display("FAIL oor_first_kept: got %h fault=%b expected %h", rd, f, w_first); end
    endtask

    task automatic test_latency1_back_to_back();
        logic [63:0] wd [6];
        logic [31:0] exp_d; int lat; int n_resp; int last; int extra; bit stray; int w;
        for (int k = 0; k < 6; k++) begin
            wd[k] = {$urandom, $urandom};
            @(posedge clk); @(negedge clk);
            d1req.valid = 1'b1; d1req.addr = BASE + 64'h40 + 64'(8 * k);
            d1req.size = 3'd3; d1req.strobe = 8'hFF; d1req.data = wd[k];
            lat = -1;
            for (int c = 1; c <= 10 && lat < 0; c++) begin
                @(posedge clk); @(negedge clk);
                if (d1resp.data_ok) lat = c;
            end
            d1req = '0;
            n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL l1_write_latency[%0d]: got %0d expected 1", k, lat); end
        end
        @(posedge clk); @(negedge clk);
        i1req.valid = 1'b1; i1req.addr = BASE + 64'h40;
        n_resp = 0; last = 0; stray = 1'b0;
        for (int c = 1; c <= 40 && n_resp < 8; c++) begin
            @(posedge clk); @(negedge clk);
            if (d1resp.data_ok || access_fault1) stray = 1'b1;
            if (i1resp.data_ok) begin
                w = n_resp % 6;
                exp_d = (n_resp % 2 == 1) ? wd[w][63:32] : wd[w][31:0];
                n_checks++; if (i1resp.data !== exp_d) begin
                    n_fail++; $display("FAIL l1_data[%0d]: got %h expected %h", n_resp, i1resp.data, exp_d); end
                n_checks++; if ((c - last) !== ((n_resp == 0) ? 1 : 2)) begin
                    n_fail++; $display("FAIL l1_spacing[%0d]: got %0d expected %0d", n_resp, c - last, (n_resp == 0) ? 1 : 2); end
                last = c;
                n_resp++;
                if (n_resp < 8) i1req.addr = BASE + 64'h40 + 64'(8 * (n_resp % 6)) + 64'(4 * (n_resp % 2));
                else i1req = '0;
            end
        end
        i1req = '0;
        extra = 0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (i1resp.data_ok || d1resp.data_ok) extra++;
        end
        n_checks++; if (n_resp !== 8 || extra !== 0 || stray) begin
            n_fail++; $display("FAIL l1_count: got %0d responses, %0d extra, stray=%b expected 8/0/0", n_resp, extra, stray); end
    endtask

    task automatic test_reset_mid_txn();
        logic [63:0] rd; logic f; int lat; bit st; int seen; int c;
        logic [63:0] old_w;
        old_w = 64'h5A5A_0F0F_C3C3_9696;
        dbus_txn(BASE + 64'h20, 8'hFF, old_w, 1'b0, rd, f, lat, st);
        @(posedge clk); @(negedge clk);
        dreq.valid = 1'b1; dreq.addr = BASE + 64'h20; dreq.size = 3'd3; dreq.strobe = 8'hFF;
        dreq.data = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if ({iresp, dresp, access_fault} !== '0) begin
            n_fail++; $display("FAIL busy_reset_outputs: got iresp=%h dresp=%h fault=%b expected 0", iresp, dresp, access_fault); end
        dreq = '0;
        @(negedge clk); reset = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (iresp.data_ok || dresp.data_ok || access_fault) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL reset_no_late_resp: got %0d expected 0", seen); end
        dbus_txn(BASE + 64'h20, 8'h00, 64'd0, 1'b0, rd, f, lat, st);
        n_checks++; if (rd !== old_w) begin n_fail++; $display("FAIL reset_write_dropped: got %h expected %h", rd, old_w); end

        // Reset landing in the response cycle clears the outputs without waiting for a clock.
        @(posedge clk); @(negedge clk);
        dreq.valid = 1'b1; dreq.addr = BASE + 64'h20; dreq.size = 3'd3; dreq.strobe = 8'h00;
        c = 0;
        while (!dresp.data_ok && c < 20) begin
            @(posedge clk); @(negedge clk);
            c++;
        end
        n_checks++; if (c !== LAT) begin n_fail++; $display("FAIL resp_reach: got %0d expected %0d", c, LAT); end
        reset = 1'b0;
        #1;
        n_checks++; if (dresp !== '0 || access_fault !== 1'b0) begin
            n_fail++; $display("FAIL resp_reset_outputs: got dresp=%h fault=%b expected 0", dresp, access_fault); end
        dreq = '0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [63:0] ref_mem [16];
        logic [63:0] base_r; logic [63:0] addr; logic [63:0] rd; logic [63:0] wd; logic [63:0] exp64;
        logic [31:0] rd32; logic [31:0] exp32; logic [7:0] stb;
        logic f; int lat; bit st; int k; int op; int h; bit drop;
        base_r = BASE + 64'h200;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = {$urandom, $urandom};
            dbus_txn(base_r + 64'(8 * i), 8'hFF, ref_mem[i], 1'b0, rd, f, lat, st);
        end
        for (int n = 0; n < 40; n++) begin
            k  = $urandom_range(0, 15);
            op = $urandom_range(0, 2);
            addr = base_r + 64'(8 * k);
            if (op == 0) begin
                exp64 = ref_mem[k];
                dbus_txn(addr, 8'h00, {$urandom, $urandom}, 1'b0, rd, f, lat, st);
                n_checks++; if (rd !== exp64 || lat !== LAT || f !== 1'b0 || st) begin
                    n_fail++; $display("FAIL rnd_dread[%0d]: got %h lat=%0d fault=%b stray=%b expected %h", n, rd, lat, f, st, exp64); end
            end else if (op == 1) begin
                h = $urandom_range(0, 1);
                exp32 = (h == 1) ? ref_mem[k][63:32] : ref_mem[k][31:0];
                ibus_txn(addr + 64'(4 * h), rd32, f, lat, st);
                n_checks++; if (rd32 !== exp32 || lat !== LAT || f !== 1'b0 || st) begin
                    n_fail++; $display("FAIL rnd_iread[%0d]: got %h lat=%0d fault=%b stray=%b expected %h", n, rd32, lat, f, st, exp32); end
            end else begin
                stb  = 8'($urandom_range(1, 255));
                wd   = {$urandom, $urandom};
                drop = ($urandom_range(0, 3) == 0);
                dbus_txn(addr, stb, wd, drop, rd, f, lat, st);
                for (int b = 0; b < 8; b++) begin
                    if (stb[b]) ref_mem[k][8*b +: 8] = wd[8*b +: 8];
                end
                n_checks++; if (rd !== 64'd0 || lat !== LAT || f !== 1'b0 || st) begin
                    n_fail++; $display("FAIL rnd_write[%0d]: got data=%h lat=%0d fault=%b stray=%b expected 0/%0d/0/0", n, rd, lat, f, st, LAT); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_arbitration();
        test_out_of_range();
        test_latency1_back_to_back();
        test_reset_mid_txn();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Bus-side responder that terminates the core's instruction bus (ibus) and data bus (dbus), serving both from one shared single-port 64-bit-wide SRAM model.
- Used as the fast on-chip memory target for core-level simulation and for FPGA bring-up without the external interconnect.
- Arbitrates between ibus and dbus, applies a programmable access latency, and returns handshake responses in the codebase's valid / addr_ok / data_ok protocol.

Parameters:
- DEPTH_WORDS, 4096, number of 64-bit words; must be a power of two.
- BASE_ADDR, 64'h8000_0000, byte address mapped to word 0.
- LATENCY, 2, cycles from grant to the data_ok pulse; must be at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ireq  in  ibus_req_t  fields: valid; addr[63:0]
- iresp  out  ibus_resp_t  fields: addr_ok; data_ok; data[31:0]
- dreq  in  dbus_req_t  fields: valid; addr[63:0]; size[2:0]; strobe[7:0]; data[63:0]
- dresp  out  dbus_resp_t  fields: addr_ok; data_ok; data[63:0]
- access_fault  out  1  one-cycle pulse coincident with the data_ok of an out-of-range access

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; latency counter is 0.
  - Round-robin pointer is set to favour dbus.
  - All response fields and access_fault are 0.
  - SRAM contents are not cleared and are retained across reset.
- FSM states IDLE, BUSY, RESP:
  - IDLE: if either valid is high, grant one requester, latch its request (addr, size, strobe, data, source), load counter with LATENCY-1, then go to BUSY. Go to RESP directly if LATENCY==1.
  - BUSY: decrement the counter; at 0, go to RESP.
  - RESP: for exactly one cycle, drive addr_ok=1 and data_ok=1 with data on the granted port only, then return to IDLE.
  - A request arriving in the cycle after RESP may be granted immediately, so the idle gap is zero.
- Arbitration:
  - Both valid in IDLE: grant the side the pointer favours, then point the pointer at the other side.
  - Single valid: grant it; the pointer is unchanged.
  - No combinational path from valid to any response output.
- Address check: word index = (addr - BASE_ADDR) >> 3. An access is in range iff BASE_ADDR <= addr < BASE_ADDR + 8*DEPTH_WORDS.
- Reads:
  - SRAM is read in the RESP cycle using the latched address.
  - dresp.data is the full aligned 64-bit word; the core extracts bytes.
  - iresp.data is word[63:32] if addr[2]=1, else word[31:0].
- Writes (dbus with strobe != 0):
  - At the RESP clock edge, write byte i of the latched data where strobe[i]=1.
  - dresp.data = 0.
  - size is latched but not used for masking; strobe is authoritative.
- Out-of-range accesses:
  - Still complete with normal latency.
  - data=0, writes are suppressed, access_fault=1 in the RESP cycle.
- Protocol:
  - The initiator holds valid and payload until data_ok.
  - If valid drops mid-transaction, the transaction still completes, including the write and the pulse.
  - Responses are never issued on the non-granted port.
- Reset during BUSY/RESP: the transaction is abandoned, and any write not yet committed is dropped.

Test Plan:
- dbus write 64'h1122334455667788 to 0x8000_0010, strobe 8'hFF; then dbus read of the same address.
  - Required: data_ok exactly LATENCY cycles after grant.
  - Required: read returns 64'h1122334455667788.
- Partial write 64'hAAAA_AAAA_AAAA_AAAA with strobe 8'h0F over the above; then ibus reads of 0x8000_0010 and 0x8000_0014.
  - Required: iresp.data = 32'hAAAAAAAA and 32'h11223344 respectively.
- ireq and dreq both valid from reset for 4 transactions.
  - Required: grant order dbus, ibus, dbus, ibus; each data_ok is a single cycle on the correct port only.
- dbus write to 0x7FFF_FFF8, then read of 0x8000_0000 + 8*DEPTH_WORDS.
  - Required: both complete, access_fault pulses twice, read data 0, memory unchanged.
- LATENCY=1 with back-to-back ibus requests held valid.
  - Required: one response every 2 cycles, no dropped or duplicated data_ok.
- Assert reset=0 during BUSY of a write to 0x8000_0020.
  - Required: outputs go to 0 immediately, no data_ok appears after reset release, and a later read returns the old contents.
